// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with synchroniser, mid-bit sampling and holding register
//
// Receives 8N1 frames on the asynchronous rxd line and presents each good
// byte in a holding register with a ready/read handshake. It also raises
// sticky framing-error and overrun flags.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   rxd        asynchronous serial input, idle high
//   rx_read    one-cycle strobe: consumer has taken rx_data
//   rx_data    last good received byte, held until the next good byte
//   rx_valid   one-cycle pulse when a good byte is loaded into rx_data
//   rx_ready   an unread byte is waiting in rx_data
//   rx_busy    receiver FSM is not idle
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a good byte completed while rx_ready was still set
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;

    // The chain is preset to all ones, so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_ready  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // Read clears come first so that any set below in the same
            // cycle takes priority.
            if (rx_read) begin
                rx_ready  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state   <= S_START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                // Sample at mid start bit; a high line here was only a glitch.
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Return to IDLE right at the stop sample so that a
                // back-to-back start edge half a bit later is caught.
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            rx_ready <= 1'b1;
                            if (rx_ready && !rx_read) begin
                                overrun <= 1'b1;
                            end
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A held-low line (break) must not retrigger reception.
                S_BREAK: begin
                    if (rxd_s) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int base_cnt = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_read   (rx_read),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
    endtask

    // One 8N1 frame, 10*CPB cycles. rx_read is raised for the single cycle
    // whose closing edge is iteration read_at (-1 = never).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int read_at);
        for (int c = 0; c < 10 * CPB; c++) begin
            int b;
            b = c / CPB;
            if (b == 0) rxd = 1'b0;
            else if (b <= 8) rxd = d[b-1];
            else rxd = stop;
            rx_read = (c == read_at);
            tick(1);
        end
        rx_read = 1'b0;
    endtask

    initial begin
        // Reset and idle line
        tick(3);
        reset = 1'b0;
        tick(100);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_ready", rx_ready, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_vcnt", valid_cnt, 0);

        // Single good byte, then read
        base_cnt = valid_cnt;
        send_frame(8'hA5, 1'b1, -1);
        tick(2);
        chk("a5_vcnt", valid_cnt - base_cnt, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_ready", rx_ready, 1'b1);
        chk("a5_busy", rx_busy, 1'b0);
        pulse_read();
        chk("a5_rd_ready", rx_ready, 1'b0);
        chk("a5_rd_data", rx_data, 8'hA5);

        // Back-to-back with no read -> overrun
        base_cnt = valid_cnt;
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hC3, 1'b1, -1);
        tick(2);
        chk("b2b_vcnt", valid_cnt - base_cnt, 2);
        chk("b2b_data", rx_data, 8'hC3);
        chk("b2b_ovr", overrun, 1'b1);
        chk("b2b_ready", rx_ready, 1'b1);
        pulse_read();
        chk("b2b_rd_ovr", overrun, 1'b0);
        chk("b2b_rd_ready", rx_ready, 1'b0);

        // Framing error followed by a held-low break
        base_cnt = valid_cnt;
        send_frame(8'h5A, 1'b0, -1);
        tick(40);
        chk("fe_ferr", frame_err, 1'b1);
        chk("fe_busy", rx_busy, 1'b1);
        chk("fe_vcnt", valid_cnt - base_cnt, 0);
        chk("fe_data", rx_data, 8'hC3);
        chk("fe_ready", rx_ready, 1'b0);
        rxd = 1'b1;
        tick(5);
        chk("fe_idle_busy", rx_busy, 1'b0);
        chk("fe_sticky", frame_err, 1'b1);
        pulse_read();
        chk("fe_rd_ferr", frame_err, 1'b0);
        tick(10);

        // Short low glitch
        base_cnt = valid_cnt;
        rxd = 1'b0;
        tick(4);
        chk("gl_busy_in", rx_busy, 1'b1);
        rxd = 1'b1;
        tick(20);
        chk("gl_busy", rx_busy, 1'b0);
        chk("gl_vcnt", valid_cnt - base_cnt, 0);
        chk("gl_ferr", frame_err, 1'b0);
        chk("gl_ovr", overrun, 1'b0);
        chk("gl_ready", rx_ready, 1'b0);

        // Reset during bit 3 of 8'hFF
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b1;
        tick(3 * CPB + CPB / 2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("mr_data", rx_data, 8'h00);
        chk("mr_busy", rx_busy, 1'b0);
        chk("mr_ready", rx_ready, 1'b0);
        chk("mr_valid", rx_valid, 1'b0);
        tick(5 * CPB);
        chk("mr_busy_after", rx_busy, 1'b0);

        base_cnt = valid_cnt;
        send_frame(8'h81, 1'b1, -1);
        tick(2);
        chk("81_data", rx_data, 8'h81);
        chk("81_ready", rx_ready, 1'b1);
        chk("81_vcnt", valid_cnt - base_cnt, 1);

        // rx_read at the edge where the next good byte completes:
        // the stop sample falls on the edge closing iteration 154.
        base_cnt = valid_cnt;
        send_frame(8'h42, 1'b1, 154);
        tick(2);
        chk("sim_data", rx_data, 8'h42);
        chk("sim_ready", rx_ready, 1'b1);
        chk("sim_ovr", overrun, 1'b0);
        chk("sim_vcnt", valid_cnt - base_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
